// File: rtl/ram_dump_ctrl.sv
// +----------------------------------------------------------------------------+
// | ram_dump_ctrl : fills a RAM with an address ramp, dumps it to a UART.      |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_dump_ctrl #(
  parameter logic [7:0] LAST_ADDR = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_start,
  input  logic       i_rd_start,
  output logic       o_ram_wren,
  output logic [7:0] o_ram_addr,
  output logic [7:0] o_ram_wdata,
  input  logic [7:0] i_ram_rdata,
  output logic [7:0] o_tx_data,
  output logic       o_tx_send_en,
  input  logic       i_tx_done,
  output logic       o_state_led,
  output logic       o_op_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ADDR  = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_TX_START = 3'd4,
    S_TX_WAIT  = 3'd5
  } state_t;

  state_t     r_state,  w_nxt_state;
  logic [7:0] r_addr,   w_nxt_addr;
  logic [7:0] r_wdata,  w_nxt_wdata;
  logic       r_wren,   w_nxt_wren;
  logic [7:0] r_tx_data, w_nxt_tx_data;
  logic       r_send,   w_nxt_send;
  logic       r_led,    w_nxt_led;
  logic       r_op_done, w_nxt_op_done;

  logic       w_at_last;
  logic [7:0] w_addr_inc;

  assign w_at_last  = (r_addr == LAST_ADDR);
  assign w_addr_inc = r_addr + 8'd1;

  // Every output is computed one cycle ahead and registered, so none can glitch.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_addr    = r_addr;
    w_nxt_wdata   = r_wdata;
    w_nxt_wren    = 1'b0;
    w_nxt_tx_data = r_tx_data;
    w_nxt_send    = 1'b0;
    w_nxt_op_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_wr_start) begin
          w_nxt_state = S_WRITE;
          w_nxt_addr  = 8'd0;
          w_nxt_wdata = 8'd0;
          w_nxt_wren  = 1'b1;
        end else if (i_rd_start) begin
          w_nxt_state = S_RD_ADDR;
          w_nxt_addr  = 8'd0;
        end
      end
      S_WRITE: begin
        if (w_at_last) begin
          w_nxt_state   = S_IDLE;
          w_nxt_op_done = 1'b1;
        end else begin
          w_nxt_addr  = w_addr_inc;
          w_nxt_wdata = w_addr_inc;
          w_nxt_wren  = 1'b1;
        end
      end
      S_RD_ADDR: w_nxt_state = S_RD_WAIT;
      S_RD_WAIT: begin
        w_nxt_state   = S_TX_START;
        w_nxt_tx_data = i_ram_rdata;
        w_nxt_send    = 1'b1;
      end
      S_TX_START: w_nxt_state = S_TX_WAIT;
      S_TX_WAIT: begin
        if (i_tx_done) begin
          if (w_at_last) begin
            w_nxt_state   = S_IDLE;
            w_nxt_op_done = 1'b1;
          end else begin
            w_nxt_state = S_RD_ADDR;
            w_nxt_addr  = w_addr_inc;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    w_nxt_led = (w_nxt_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= 8'd0;
      r_wdata   <= 8'd0;
      r_wren    <= 1'b0;
      r_tx_data <= 8'd0;
      r_send    <= 1'b0;
      r_led     <= 1'b0;
      r_op_done <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_addr    <= w_nxt_addr;
      r_wdata   <= w_nxt_wdata;
      r_wren    <= w_nxt_wren;
      r_tx_data <= w_nxt_tx_data;
      r_send    <= w_nxt_send;
      r_led     <= w_nxt_led;
      r_op_done <= w_nxt_op_done;
    end
  end

  assign o_ram_wren   = r_wren;
  assign o_ram_addr   = r_addr;
  assign o_ram_wdata  = r_wdata;
  assign o_tx_data    = r_tx_data;
  assign o_tx_send_en = r_send;
  assign o_state_led  = r_led;
  assign o_op_done    = r_op_done;

endmodule

`default_nettype wire

// File: doc/ram_dump_ctrl.md
RAM_DUMP_CTRL -- requirements
Module: ram_dump_ctrl

Interface
REQ-001 The block SHALL expose parameter LAST_ADDR, default 8'd255, meaning the final RAM address handled by the fill and dump sequences.
REQ-002 clk  input  1  system clock, 50 MHz; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 wr_start  input  1  single-cycle pulse (debounced key) requesting a RAM fill.
REQ-005 rd_start  input  1  single-cycle pulse (debounced key) requesting a RAM dump to UART.
REQ-006 ram_wren  output  1  RAM write enable.
REQ-007 ram_addr  output  8  RAM address, shared by write and read.
REQ-008 ram_wdata  output  8  RAM write data.
REQ-009 ram_rdata  input  8  RAM read data, valid the cycle after the address is registered (1-cycle synchronous read).
REQ-010 tx_data  output  8  byte for the UART byte transmitter, held stable from send pulse until tx_done.
REQ-011 tx_send_en  output  1  one-cycle pulse starting a UART byte transmission.
REQ-012 tx_done  input  1  one-cycle pulse from the UART transmitter marking byte complete.
REQ-013 state_led  output  1  high while any sequence is active.
REQ-014 op_done  output  1  one-cycle pulse when a fill or dump completes.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE, RD_ADDR, RD_WAIT, TX_START, TX_WAIT, and a done-pulse state or equivalent registered op_done.
REQ-016 In IDLE, a wr_start sampled high SHALL enter WRITE with ram_addr=0 next cycle; otherwise rd_start high SHALL enter RD_ADDR with ram_addr=0.
REQ-017 If wr_start and rd_start are sampled high in the same cycle, the block SHALL perform the fill and drop rd_start.
REQ-018 wr_start/rd_start in any non-IDLE state SHALL be ignored (not queued).
REQ-019 WRITE: each cycle ram_wren=1, ram_wdata=ram_addr; ram_addr increments by 1 each cycle; after the cycle writing LAST_ADDR -> IDLE, ram_wren=0, op_done=1 for one cycle.
REQ-020 A fill SHALL take exactly LAST_ADDR+1 cycles of ram_wren high, with no gaps.
REQ-021 RD_ADDR (1 cycle): ram_addr presented, ram_wren=0 -> RD_WAIT.
REQ-022 RD_WAIT (1 cycle) -> TX_START, capturing ram_rdata into tx_data on that transition edge.
REQ-023 TX_START: tx_send_en=1 for exactly one cycle -> TX_WAIT.
REQ-024 TX_WAIT: hold tx_data and ram_addr; on tx_done: if ram_addr==LAST_ADDR -> IDLE with op_done pulse, else ram_addr+1 -> RD_ADDR.
REQ-025 Latency SHALL be: start pulse in cycle 0 -> tx_send_en in cycle 3; tx_done in cycle k -> next tx_send_en in cycle k+3.
REQ-026 tx_done SHALL be ignored in every state except TX_WAIT; TX_WAIT SHALL wait indefinitely without re-pulsing tx_send_en.
REQ-027 ram_addr arithmetic is 8-bit; the sequence SHALL terminate at LAST_ADDR and never wrap to 0 within a sequence.
REQ-028 state_led SHALL be high in every state except IDLE, registered (no combinational glitches).
REQ-029 ram_wren SHALL never be high outside WRITE.

Reset
REQ-030 While rst_n=0: state=IDLE, ram_addr=0, ram_wdata=0, ram_wren=0, tx_data=0, tx_send_en=0, state_led=0, op_done=0, asynchronously.
REQ-031 Reset mid-sequence SHALL abort it without resume; the next start pulse restarts from address 0.

Verification
REQ-032 Reset: rst_n low 10 cycles, random inputs -> all outputs 0 throughout.
REQ-033 Fill: wr_start pulse -> 256 consecutive cycles ram_wren=1, ram_addr/ram_wdata 0x00..0xFF in order, op_done one cycle after, state_led high for 256 cycles.
REQ-034 Dump: fill, then rd_start with RAM model and tx_done returned 500 cycles after each send -> 256 tx_send_en pulses, tx_data 0x00..0xFF in order, first pulse 3 cycles after rd_start, op_done after final tx_done.
REQ-035 Collision: wr_start and rd_start in the same cycle -> fill only, zero tx_send_en; rd_start during fill -> ignored.
REQ-036 Abort: rst_n low after the 10th tx_done of a dump -> outputs 0 immediately; subsequent rd_start -> first tx_data=0x00.
REQ-037 Stall/spurious: tx_done withheld 10000 cycles -> exactly one tx_send_en, state_led high; tx_done pulse in IDLE -> no output change.
